ps2_mouse_mode_sel: RTL and testbench
=====================================

PS2_MOUSE_MODE_SEL -- requirements
Module: ps2_mouse_mode_sel

Interface
REQ-001 SHALL have parameter NUM_MODES, default 3, number of selectable modes (2..16).
REQ-002 SHALL have parameter BTN_SEL, default 1, button that advances mode (0 left, 1 right, 2 middle).
REQ-003 SHALL have parameter FILTER_LEN, default 8, clk cycles ps2_clk must be stable before a level change is accepted.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 200000, idle clk cycles mid-frame/mid-packet before resync.
REQ-005 SHALL have localparam MODE_W = max(1, clog2(NUM_MODES)).
REQ-006 clk  input  1  system clock; all logic on rising edge; only clock in the block.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 ps2_clk  input  1  PS/2 clock from mouse, asynchronous to clk.
REQ-009 ps2_data  input  1  PS/2 data from mouse, asynchronous to clk.
REQ-010 mode  output  MODE_W  current mode index, 0..NUM_MODES-1.
REQ-011 pkt_valid  output  1  one-cycle pulse, complete 3-byte packet accepted.
REQ-012 buttons  output  3  {middle, right, left} of last valid packet.
REQ-013 dx, dy  output  9 each  signed movement {sign, byte}, last valid packet.
REQ-014 parity_err, frame_err  output  1 each  one-cycle error pulses.

Function
REQ-015 ps2_clk and ps2_data SHALL pass 2-flop synchronisers; ps2_clk then through glitch filter of FILTER_LEN cycles.
REQ-016 A falling edge of the filtered ps2_clk SHALL sample synchronised ps2_data; no other edge samples.
REQ-017 Frame FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on sampled 0 (start); sampled 1 in IDLE ignored.
REQ-018 DATA SHALL shift 8 bits LSB first, then ->PARITY; PARITY samples bit, ->STOP; STOP samples bit, ->IDLE.
REQ-019 Byte accepted only if data XOR parity bits is 1 (odd parity) and stop bit is 1.
REQ-020 Parity failure SHALL pulse parity_err, discard byte, reset packet index to 0; stop failure SHALL pulse frame_err likewise; both failures -> parity_err only.
REQ-021 Packet index 0..2; byte at index 0 with bit3 = 0 SHALL be discarded silently, index stays 0.
REQ-022 On acceptance of byte at index 2: pkt_valid SHALL pulse on the cycle after the stop-bit sample; buttons = byte0[2:0], dx = {byte0[4], byte1}, dy = {byte0[5], byte2}, all updated same cycle; index -> 0.
REQ-023 mode SHALL increment on the pkt_valid cycle only when buttons[BTN_SEL] is 1 in the new packet and was 0 in the previous valid packet (press edge, held button does not repeat).
REQ-024 mode at NUM_MODES-1 SHALL wrap to 0 on increment.
REQ-025 Counter of clk cycles since last filtered falling edge; if FSM not IDLE or index != 0 and counter reaches TIMEOUT_CYC, FSM -> IDLE, index -> 0, no error pulse.
REQ-026 Outputs buttons/dx/dy/mode SHALL hold between packets; errors SHALL never change them.

Reset
REQ-027 rst_n low SHALL immediately force: mode 0, pkt_valid 0, buttons 0, dx 0, dy 0, parity_err 0, frame_err 0, FSM IDLE, index 0, previous-button 0, synchronisers and filter to 1 (bus idle), timeout counter 0.
REQ-028 Reset mid-frame or mid-packet SHALL discard partial data; first start bit after release begins a new frame at index 0.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the frame-state enumeration, PKT_BYTES = 3, and bit positions for sync bit (3), sign bits (4, 5) and buttons.
REQ-030 One sub-module ps2_rx_byte (sync, filter, frame FSM, parity/stop check, byte-valid strobe); packet assembly, timeout and mode logic in the top.

Verification
REQ-031 Packet 0x0A, 0x05, 0xFB, all parity/stop correct, previous buttons 0 -> pkt_valid one pulse, buttons 3'b010, dx 9'h005, dy 9'h0FB, mode 0->1.
REQ-032 Same packet sent 3 more times with right held -> mode stays 1; packet 0x08,0,0 then 0x0A,0,0 twice with release between -> mode 1->2->0 (wrap, NUM_MODES 3).
REQ-033 Byte 0x0A with parity bit 1 (even) -> parity_err one pulse, no pkt_valid, next correct 3 bytes -> pkt_valid.
REQ-034 Stop bit 0 on byte 2 -> frame_err pulse, mode and outputs unchanged; leading byte 0x00 (bit3 0) -> dropped, following 0x08,0x01,0x02 -> pkt_valid, dx 9'h001.
REQ-035 Two bytes then silence TIMEOUT_CYC cycles -> index 0, then full packet -> correct pkt_valid; 3-cycle ps2_clk glitch (FILTER_LEN 8) -> no bit sampled.
REQ-036 rst_n low during bit 5 of byte 1 with mode 2 -> mode 0 immediately, all outputs 0, next packet decoded from index 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg : shared frame-state encoding and packet field positions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam int PKT_BYTES = 3;
  localparam int SYNC_BIT  = 3;
  localparam int XSIGN_BIT = 4;
  localparam int YSIGN_BIT = 5;
  localparam int BTN_LSB   = 0;
  localparam int BTN_MSB   = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_byte.sv
// ---------------------------------------------------------------------------
// ps2_rx_byte : synchronise/filter PS/2 lines and deframe one 11-bit byte
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx_byte
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       abort,
  output logic       fall,
  output logic       busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_data_sync;
  logic             r_clk_filt;
  logic [CNT_W-1:0] r_filt_cnt;
  frame_state_t     r_state;
  frame_state_t     w_state_next;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par_bit;
  logic             w_sclk;
  logic             w_sdata;

  assign w_sclk  = r_clk_sync[1];
  assign w_sdata = r_data_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // A new level is adopted only after it has differed for FILTER_LEN cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_sclk == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
      r_clk_filt <= w_sclk;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign fall = r_clk_filt && !w_sclk && (r_filt_cnt == CNT_W'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (abort) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (fall) begin
      case (r_state)
        ST_IDLE:   if (!w_sdata) w_state_next = ST_DATA;
        ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
        ST_PARITY: w_state_next = ST_STOP;
        ST_STOP:   w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else if (abort) begin
      r_bit_cnt <= '0;
    end else if (fall) begin
      if (r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
      end else if (r_state == ST_DATA) begin
        r_shift   <= {w_sdata, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else if (r_state == ST_PARITY) begin
        r_par_bit <= w_sdata;
      end
    end
  end

  // A bad parity bit takes precedence over a bad stop bit.
  always_comb begin
    byte_valid = 1'b0;
    parity_err = 1'b0;
    frame_err  = 1'b0;
    if (fall && r_state == ST_STOP && !abort) begin
      if (!(^{r_shift, r_par_bit})) begin
        parity_err = 1'b1;
      end else if (!w_sdata) begin
        frame_err = 1'b1;
      end else begin
        byte_valid = 1'b1;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign byte_data = r_shift;

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_mode_sel.sv
// ---------------------------------------------------------------------------
// ps2_mouse_mode_sel : PS/2 mouse packet decoder with button-driven mode cycling
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_mouse_mode_sel
  import ps2_pkg::*;
#(
  parameter int NUM_MODES   = 3,
  parameter int BTN_SEL     = 1,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000,
  localparam int MODE_W     = clog2_min1(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [MODE_W-1:0] mode,
  output logic              pkt_valid,
  output logic [2:0]        buttons,
  output logic [8:0]        dx,
  output logic [8:0]        dy,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic            w_fall;
  logic            w_busy;
  logic            w_byte_valid;
  logic [7:0]      w_byte;
  logic            w_perr;
  logic            w_ferr;
  logic            w_timeout;
  logic [1:0]      r_idx;
  logic [7:0]      r_byte0;
  logic [7:0]      r_byte1;
  logic            r_prev_btn;
  logic [TO_W-1:0] r_to_cnt;

  ps2_rx_byte #(
    .FILTER_LEN (FILTER_LEN)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .abort      (w_timeout),
    .fall       (w_fall),
    .busy       (w_busy),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte),
    .parity_err (w_perr),
    .frame_err  (w_ferr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYC)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (w_busy || r_idx != 2'd0) && !w_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_byte0    <= '0;
      r_byte1    <= '0;
      r_prev_btn <= 1'b0;
      mode       <= '0;
      pkt_valid  <= 1'b0;
      buttons    <= '0;
      dx         <= '0;
      dy         <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pkt_valid  <= 1'b0;
      parity_err <= w_perr;
      frame_err  <= w_ferr;
      if (w_timeout || w_perr || w_ferr) begin
        r_idx <= '0;
      end else if (w_byte_valid) begin
        if (r_idx == 2'd0) begin
          // Bytes without the always-one marker cannot start a packet.
          if (w_byte[SYNC_BIT]) begin
            r_byte0 <= w_byte;
            r_idx   <= 2'd1;
          end
        end else if (r_idx == 2'(PKT_BYTES - 2)) begin
          r_byte1 <= w_byte;
          r_idx   <= 2'(PKT_BYTES - 1);
        end else begin
          r_idx      <= '0;
          pkt_valid  <= 1'b1;
          buttons    <= r_byte0[BTN_MSB:BTN_LSB];
          dx         <= {r_byte0[XSIGN_BIT], r_byte1};
          dy         <= {r_byte0[YSIGN_BIT], w_byte};
          r_prev_btn <= r_byte0[BTN_SEL];
          if (r_byte0[BTN_SEL] && !r_prev_btn) begin
            if (mode == MODE_W'(NUM_MODES - 1)) begin
              mode <= '0;
            end else begin
              mode <= mode + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_mode_sel.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_mode_sel : directed and random PS/2 frames against a packet model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ps2_mouse_mode_sel;

  localparam int NUM_MODES   = 3;
  localparam int BTN_SEL     = 1;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 600;
  localparam int HALF        = 20;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] mode;
  logic       pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       parity_err;
  logic       frame_err;

  ps2_mouse_mode_sel #(
    .NUM_MODES   (NUM_MODES),
    .BTN_SEL     (BTN_SEL),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .mode       (mode),
    .pkt_valid  (pkt_valid),
    .buttons    (buttons),
    .dx         (dx),
    .dy         (dy),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pkt_cnt  = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;

  // Pulse counters: a pulse held two cycles would count twice.
  always @(negedge clk) begin
    if (pkt_valid)  pkt_cnt++;
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
  end

  logic [7:0] q[$];
  int         exp_pkt = 0, exp_perr = 0, exp_ferr = 0;
  int         m_mode = 0;
  logic [2:0] m_btn = '0;
  logic [8:0] m_dx = '0, m_dy = '0;
  bit         m_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_btn  = '0;
    m_dx   = '0;
    m_dy   = '0;
    m_prev = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par) begin
      exp_perr++;
      q.delete();
    end else if (bad_stop) begin
      exp_ferr++;
      q.delete();
    end else if (q.size() == 0 && !b[3]) begin
      // dropped: not a valid packet header
    end else begin
      q.push_back(b);
      if (q.size() == 3) begin
        exp_pkt++;
        m_btn = q[0][2:0];
        m_dx  = {q[0][4], q[1]};
        m_dy  = {q[0][5], q[2]};
        if (m_btn[BTN_SEL] && !m_prev) m_mode = (m_mode + 1) % NUM_MODES;
        m_prev = m_btn[BTN_SEL];
        q.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pkt"},  pkt_cnt,  exp_pkt);
    chk({tag, ".perr"}, perr_cnt, exp_perr);
    chk({tag, ".ferr"}, ferr_cnt, exp_ferr);
    chk({tag, ".mode"}, int'(mode), m_mode);
    chk({tag, ".btn"},  int'(buttons), int'(m_btn));
    chk({tag, ".dx"},   int'(dx), int'(m_dx));
    chk({tag, ".dy"},   int'(dy), int'(m_dy));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(HALF);
    model_frame(b, bad_par, bad_stop);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input string tag);
    send_frame(b0, 1'b0, 1'b0);
    send_frame(b1, 1'b0, 1'b0);
    send_frame(b2, 1'b0, 1'b0);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] b;
    bit bp, bs;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    check_all("reset");
    chk("reset.pv", int'(pkt_valid), 0);
    rst_n = 1'b1;
    wait_clk(5);

    // first press of the selected button
    send_pkt(8'h0A, 8'h05, 8'hFB, "basic");
    chk("basic.btn_k", int'(buttons), 3'b010);
    chk("basic.dx_k", int'(dx), 9'h005);
    chk("basic.dy_k", int'(dy), 9'h0FB);
    chk("basic.mode_k", int'(mode), 1);

    for (int i = 0; i < 3; i++) send_pkt(8'h0A, 8'h05, 8'hFB, "held");
    chk("held.mode_k", int'(mode), 1);
    send_pkt(8'h08, 8'h00, 8'h00, "rel1");
    send_pkt(8'h0A, 8'h00, 8'h00, "press2");
    chk("press2.mode_k", int'(mode), 2);
    send_pkt(8'h08, 8'h00, 8'h00, "rel2");
    send_pkt(8'h0A, 8'h00, 8'h00, "wrap");
    chk("wrap.mode_k", int'(mode), 0);

    send_frame(8'h0A, 1'b1, 1'b0);
    check_all("parity");
    send_pkt(8'h09, 8'h11, 8'h22, "after_par");

    send_frame(8'h0C, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1);
    check_all("stop");

    send_frame(8'h00, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h01, 8'h02, "drop");
    chk("drop.dx_k", int'(dx), 9'h001);

    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0);
    wait_clk(TIMEOUT_CYC + 50);
    q.delete();
    send_pkt(8'h38, 8'h7F, 8'h80, "timeout");

    ps2_data = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(HALF);
    ps2_data = 1'b1;
    wait_clk(HALF);
    send_pkt(8'h1B, 8'hA5, 8'h5A, "glitch");

    // advance to mode 2 before the mid-frame reset
    for (int i = 0; i < 6 && m_mode != 2; i++) begin
      send_pkt(8'h08, 8'h00, 8'h00, "pre_rel");
      send_pkt(8'h0A, 8'h00, 8'h00, "pre_press");
    end
    chk("pre_rst.mode", int'(mode), 2);
    send_frame(8'h0A, 1'b0, 1'b0);
    b = 8'h3C;
    ps2_data = 1'b0;
    wait_clk(HALF); ps2_clk = 1'b0; wait_clk(HALF); ps2_clk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ps2_data = b[i];
      wait_clk(HALF); ps2_clk = 1'b0; wait_clk(HALF); ps2_clk = 1'b1;
    end
    ps2_data = b[5];
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(12);
    rst_n = 1'b0;
    #1;
    chk("rst.mode", int'(mode), 0);
    chk("rst.btn", int'(buttons), 0);
    chk("rst.dx", int'(dx), 0);
    chk("rst.dy", int'(dy), 0);
    chk("rst.pv", int'(pkt_valid), 0);
    model_reset();
    wait_clk(HALF);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    send_pkt(8'h2A, 8'h10, 8'h20, "post_rst");

    for (int k = 0; k < 80; k++) begin
      b  = 8'($urandom);
      if (q.size() == 0) b[3] = ($urandom_range(7) != 0);
      bp = ($urandom_range(15) == 0);
      bs = ($urandom_range(15) == 0);
      send_frame(b, bp, bs);
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
